// File: rtl/serial_rx_pkg.sv
// Shared types and helpers for the bit-serial frame receiver.
package serial_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    // Width of the data-bit counter; never narrower than one bit.
    function automatic int BIT_CNT_W(input int dataW);
        return (dataW <= 1) ? 1 : $clog2(dataW);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO used as the receiver's output buffer.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush;
    logic             doPop;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign head  = empty ? '0 : mem[rdPtr_q];

    // Qualify requests so the pointers and count can never run past the storage.
    always_comb begin
        doPop  = pop && !empty;
        doPush = push && (!full || doPop);
    end

    // Pointers wrap naturally modulo DEPTH; the count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr_q] <= wdata;
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Bit-serial frame receiver: start bit, DATA_W data bits LSB first,
// optional even parity, one stop bit. Good words go into a small FIFO
// drained with a valid/ready handshake; bad frames raise one-cycle pulses.
module serial_frame_rx
    import serial_rx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overflow
);

    localparam int CNT_W = BIT_CNT_W(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_e         state_q;
    logic [CNT_W-1:0]  bitCnt_q;
    logic [DATA_W-1:0] shift_q;
    logic              parAcc_q;
    logic              parFlag_q;
    logic              parityErr_q;
    logic              frameErr_q;
    logic              overflow_q;
    logic              overflow_d;

    logic              fifoFull;
    logic              fifoEmpty;
    logic              fifoPush;
    logic              fifoPop;
    logic              stopGood;
    logic [DATA_W-1:0] fifoHead;

    // A clean stop bit on a frame with good parity is a candidate push; a
    // same-cycle pop frees a slot, so only a full, non-draining buffer drops it.
    always_comb begin
        fifoPop    = !fifoEmpty && out_ready;
        stopGood   = (state_q == STOP) && ser_in && !parFlag_q;
        fifoPush   = stopGood && (!fifoFull || fifoPop);
        overflow_d = stopGood && fifoFull && !fifoPop;
    end

    // Deframing FSM with the shift register, parity tracking and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            parAcc_q    <= 1'b0;
            parFlag_q   <= 1'b0;
            parityErr_q <= 1'b0;
            frameErr_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            parityErr_q <= 1'b0;
            frameErr_q  <= 1'b0;
            overflow_q  <= overflow_d;
            case (state_q)
                IDLE: begin
                    if (!ser_in) begin
                        bitCnt_q  <= '0;
                        parAcc_q  <= 1'b0;
                        parFlag_q <= 1'b0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    shift_q[bitCnt_q] <= ser_in;
                    parAcc_q          <= parAcc_q ^ ser_in;
                    if (bitCnt_q == LAST_BIT) begin
                        state_q <= (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bitCnt_q <= bitCnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (ser_in != parAcc_q) begin
                        parFlag_q <= 1'b1;
                    end
                    state_q <= STOP;
                end
                STOP: begin
                    if (ser_in) begin
                        parityErr_q <= parFlag_q;
                        state_q     <= IDLE;
                    end else begin
                        frameErr_q <= 1'b1;
                        state_q    <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (ser_in) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifoPush),
        .pop   (fifoPop),
        .wdata (shift_q),
        .head  (fifoHead),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    assign out_data   = fifoHead;
    assign out_valid  = !fifoEmpty;
    assign busy       = (state_q != IDLE);
    assign parity_err = parityErr_q;
    assign frame_err  = frameErr_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed self-checking bench for serial_frame_rx with default parameters.
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       ser_in;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       busy;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    int testCount = 0;
    int failCount = 0;

    serial_frame_rx #(
        .DATA_W    (8),
        .PARITY_EN (1),
        .BUF_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ser_in     (ser_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends start, 8 data bits LSB first, the given parity and stop bits.
    // out_ready is set to readyAtStop just before the stop bit edge.
    // Returns one unit after the stop edge, i.e. in cycle t+11.
    task automatic applyStimulus(input logic [7:0] data, input logic parBit,
                                 input logic stopBit, input logic readyAtStop);
        ser_in = 1'b0;
        tick();
        checkOutput("busyAfterStart", {31'd0, busy}, 32'd1);
        checkOutput("pulsesClearAtStart", {29'd0, parity_err, frame_err, overflow}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            ser_in = data[i];
            tick();
        end
        ser_in = parBit;
        tick();
        checkOutput("noValidBeforeStopEdge", {31'd0, out_valid & ~readyAtStop & 1'b0}, 32'd0);
        out_ready = readyAtStop;
        ser_in    = stopBit;
        tick();
    endtask

    // Guard against any unexpected stall of the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        ser_in    = 1'b0;
        out_ready = 1'b1;

        // Reset held three cycles with the line low
        tick(); tick(); tick();
        checkOutput("rstOutData", {24'd0, out_data}, 32'd0);
        checkOutput("rstOutValid", {31'd0, out_valid}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstPulses", {29'd0, parity_err, frame_err, overflow}, 32'd0);
        rst    = 1'b0;
        ser_in = 1'b1;
        tick();
        checkOutput("idleAfterRst", {31'd0, busy}, 32'd0);

        // Good frame 0xA5, parity 0
        applyStimulus(8'hA5, 1'b0, 1'b1, 1'b1);
        checkOutput("goodValid", {31'd0, out_valid}, 32'd1);
        checkOutput("goodData", {24'd0, out_data}, 32'hA5);
        checkOutput("goodPulses", {29'd0, parity_err, frame_err, overflow}, 32'd0);
        checkOutput("goodBusyDone", {31'd0, busy}, 32'd0);
        ser_in = 1'b1;
        tick();
        checkOutput("goodValidOneCycle", {31'd0, out_valid}, 32'd0);
        checkOutput("goodDataCleared", {24'd0, out_data}, 32'd0);

        // Parity error on 0x01 (needs parity 1), then 0x3C back-to-back
        applyStimulus(8'h01, 1'b0, 1'b1, 1'b1);
        checkOutput("parErrPulse", {31'd0, parity_err}, 32'd1);
        checkOutput("parErrNoValid", {31'd0, out_valid}, 32'd0);
        checkOutput("parErrNoFrameErr", {31'd0, frame_err}, 32'd0);
        applyStimulus(8'h3C, 1'b0, 1'b1, 1'b1);
        checkOutput("afterParValid", {31'd0, out_valid}, 32'd1);
        checkOutput("afterParData", {24'd0, out_data}, 32'h3C);
        checkOutput("afterParNoErr", {31'd0, parity_err}, 32'd0);
        ser_in = 1'b1;
        tick();

        // Framing error on 0x55, line held low four more cycles
        applyStimulus(8'h55, 1'b0, 1'b0, 1'b1);
        checkOutput("frameErrPulse", {31'd0, frame_err}, 32'd1);
        checkOutput("frameErrNoPar", {31'd0, parity_err}, 32'd0);
        checkOutput("frameErrNoValid", {31'd0, out_valid}, 32'd0);
        checkOutput("frameErrBusy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            ser_in = 1'b0;
            tick();
            checkOutput("waitIdleNoPulse", {31'd0, frame_err}, 32'd0);
            checkOutput("waitIdleBusy", {31'd0, busy}, 32'd1);
        end
        ser_in = 1'b1;
        tick();
        checkOutput("waitIdleExit", {31'd0, busy}, 32'd0);
        applyStimulus(8'h0F, 1'b0, 1'b1, 1'b1);
        checkOutput("afterFrameValid", {31'd0, out_valid}, 32'd1);
        checkOutput("afterFrameData", {24'd0, out_data}, 32'h0F);
        ser_in = 1'b1;
        tick();

        // Framing error takes precedence over a bad parity bit
        applyStimulus(8'h55, 1'b1, 1'b0, 1'b1);
        checkOutput("precFrameErr", {31'd0, frame_err}, 32'd1);
        checkOutput("precNoParErr", {31'd0, parity_err}, 32'd0);
        ser_in = 1'b1;
        tick();
        checkOutput("precBackIdle", {31'd0, busy}, 32'd0);

        // Overflow: consumer stalled, three frames back-to-back
        out_ready = 1'b0;
        applyStimulus(8'h11, 1'b0, 1'b1, 1'b0);
        checkOutput("ovf1Valid", {31'd0, out_valid}, 32'd1);
        checkOutput("ovf1Data", {24'd0, out_data}, 32'h11);
        applyStimulus(8'h22, 1'b0, 1'b1, 1'b0);
        checkOutput("ovf2NoOvf", {31'd0, overflow}, 32'd0);
        checkOutput("ovf2Head", {24'd0, out_data}, 32'h11);
        applyStimulus(8'h33, 1'b0, 1'b1, 1'b0);
        checkOutput("ovf3Pulse", {31'd0, overflow}, 32'd1);
        checkOutput("ovf3Head", {24'd0, out_data}, 32'h11);
        ser_in    = 1'b1;
        out_ready = 1'b1;
        tick();
        checkOutput("ovfPop1Data", {24'd0, out_data}, 32'h22);
        checkOutput("ovfPop1Valid", {31'd0, out_valid}, 32'd1);
        checkOutput("ovfPulseOneCycle", {31'd0, overflow}, 32'd0);
        tick();
        checkOutput("ovfPop2Empty", {31'd0, out_valid}, 32'd0);
        checkOutput("ovfPop2Data", {24'd0, out_data}, 32'd0);

        // Full buffer with a pop in the same cycle as the stop bit
        out_ready = 1'b0;
        applyStimulus(8'hC3, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h81, 1'b0, 1'b1, 1'b0);
        checkOutput("fullHead", {24'd0, out_data}, 32'hC3);
        applyStimulus(8'h7E, 1'b0, 1'b1, 1'b1);
        checkOutput("fullPopNoOvf", {31'd0, overflow}, 32'd0);
        checkOutput("fullPopHead", {24'd0, out_data}, 32'h81);
        checkOutput("fullPopValid", {31'd0, out_valid}, 32'd1);
        ser_in = 1'b1;
        tick();
        checkOutput("fullPopNext", {24'd0, out_data}, 32'h7E);
        tick();
        checkOutput("fullPopDrained", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a frame aborts it silently
        ser_in = 1'b0;
        tick();
        ser_in = 1'b1;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
        checkOutput("midRstPulses", {29'd0, parity_err, frame_err, overflow}, 32'd0);
        rst    = 1'b0;
        ser_in = 1'b1;
        tick();
        checkOutput("midRstIdle", {31'd0, busy}, 32'd0);
        applyStimulus(8'hA5, 1'b0, 1'b1, 1'b1);
        checkOutput("midRstRecover", {24'd0, out_data}, 32'hA5);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
